// File: rtl/sparce_sasa_cache.sv
// sparce_sasa_cache: N-way set-associative SASA skip table with per-set true LRU,
// multi-cycle flush engine, saturating hit counter and registered read-back port.
package sparce_sasa_pkg;
  typedef enum logic {SASA_COND_OR = 1'b0, SASA_COND_AND = 1'b1} sasa_cond_t;
endpackage

module sparce_sasa_cache
  import sparce_sasa_pkg::*;
#(
  parameter int unsigned SASA_ENTRIES = 16,
  parameter int unsigned SASA_WAYS    = 2,
  parameter logic [31:0] SASA_ADDR    = 32'h9000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] pc,
  input  logic        pc_valid,
  input  logic        sasa_enable,
  input  logic        sasa_wen,
  input  logic        sasa_ren,
  input  logic [31:0] sasa_addr,
  input  logic [31:0] sasa_data,
  output logic [31:0] sasa_rdata,
  output logic [4:0]  sasa_rs1,
  output logic [4:0]  sasa_rs2,
  output sasa_cond_t  condition,
  output logic [4:0]  insts_to_skip,
  output logic [31:0] preceding_pc,
  output logic        valid,
  output logic        busy
);
  localparam int unsigned SETS  = SASA_ENTRIES / SASA_WAYS;
  localparam int unsigned SB    = (SETS > 1) ? $clog2(SETS) : 0;
  localparam int unsigned SET_W = (SB > 0) ? SB : 1;
  localparam int unsigned TAG_W = 16 - SB;
  localparam int unsigned AGE_W = (SASA_WAYS > 1) ? $clog2(SASA_WAYS) : 1;
  localparam int unsigned WAY_W = AGE_W;
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(SASA_WAYS - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_FLUSH = 1'b1} state_e;

  logic [SASA_WAYS-1:0] valid_q [SETS];
  logic [SASA_WAYS-1:0] valid_d [SETS];
  logic [TAG_W-1:0]     tag_q   [SETS][SASA_WAYS];
  logic [TAG_W-1:0]     tag_d   [SETS][SASA_WAYS];
  logic [15:0]          data_q  [SETS][SASA_WAYS];
  logic [15:0]          data_d  [SETS][SASA_WAYS];
  logic [AGE_W-1:0]     age_q   [SETS][SASA_WAYS];
  logic [AGE_W-1:0]     age_d   [SETS][SASA_WAYS];

  state_e           state_q, state_d;
  logic [SET_W-1:0] fl_cnt_q, fl_cnt_d;
  logic             dis_q, dis_d;
  logic [31:0]      hitcnt_q, hitcnt_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [SET_W-1:0] lk_set_s, wr_set_s;
  logic [TAG_W-1:0] lk_tag_s, wr_tag_s;
  logic             hit_s, valid_s, busy_s;
  logic [WAY_W-1:0] hit_way_s;
  logic [15:0]      hit_data_s;
  logic             wr_hit_s, inv_s;
  logic [WAY_W-1:0] wr_hit_way_s, inv_way_s, lru_way_s, wr_way_s;
  logic             wr_s, rd_s, sel_entry_s, sel_cfg_s, sel_ctrl_s, sel_hit_s;
  logic             entry_we_s, ctrl_we_s;
  logic             unused_pc_s;

  function automatic logic [AGE_W-1:0] age_next(input logic [AGE_W-1:0] age,
                                                input logic [AGE_W-1:0] hit_age,
                                                input logic             is_hit);
    logic [AGE_W-1:0] r;
    if (is_hit) begin
      r = '0;
    end else if (age < hit_age) begin
      r = age + AGE_W'(1);
    end else begin
      r = age;
    end
    return r;
  endfunction

  generate
    if (SB > 0) begin : g_idx
      assign lk_set_s = pc[2+SB-1:2];
      assign wr_set_s = sasa_data[16+SB-1:16];
    end else begin : g_noidx
      assign lk_set_s = '0;
      assign wr_set_s = '0;
    end
  endgenerate

  assign lk_tag_s    = pc[17:2+SB];
  assign wr_tag_s    = sasa_data[31:16+SB];
  assign unused_pc_s = ^pc[1:0];

  assign wr_s        = sasa_enable && sasa_wen;
  assign rd_s        = sasa_enable && sasa_ren;
  assign sel_entry_s = (sasa_addr == SASA_ADDR);
  assign sel_cfg_s   = (sasa_addr == SASA_ADDR + 32'd4);
  assign sel_ctrl_s  = (sasa_addr == SASA_ADDR + 32'd8);
  assign sel_hit_s   = (sasa_addr == SASA_ADDR + 32'd12);
  assign busy_s      = (state_q == ST_FLUSH);
  assign entry_we_s  = wr_s && sel_entry_s && !busy_s;
  assign ctrl_we_s   = wr_s && sel_ctrl_s;

  // Same-cycle lookup; descending scan leaves the lowest matching way
  always_comb begin
    hit_s     = 1'b0;
    hit_way_s = '0;
    for (int w = SASA_WAYS - 1; w >= 0; w--) begin
      hit_way_s = (valid_q[lk_set_s][w] && (tag_q[lk_set_s][w] == lk_tag_s)) ? WAY_W'(w) : hit_way_s;
      hit_s     = hit_s | (valid_q[lk_set_s][w] && (tag_q[lk_set_s][w] == lk_tag_s));
    end
  end

  assign hit_data_s    = hit_s ? data_q[lk_set_s][hit_way_s] : 16'h0;
  assign valid_s       = hit_s && !dis_q && (pc[31:18] == 14'h0) && !busy_s;
  assign valid         = valid_s;
  assign busy          = busy_s;
  assign preceding_pc  = pc;
  assign sasa_rs1      = hit_data_s[15:11];
  assign sasa_rs2      = hit_data_s[10:6];
  assign condition     = sasa_cond_t'(hit_data_s[5]);
  assign insts_to_skip = hit_data_s[4:0];
  assign sasa_rdata    = rdata_q;

  // ENTRY way choice: existing tag, else lowest invalid way, else the LRU way
  always_comb begin
    wr_hit_s     = 1'b0;
    wr_hit_way_s = '0;
    inv_s        = 1'b0;
    inv_way_s    = '0;
    lru_way_s    = '0;
    for (int w = SASA_WAYS - 1; w >= 0; w--) begin
      wr_hit_way_s = (valid_q[wr_set_s][w] && (tag_q[wr_set_s][w] == wr_tag_s)) ? WAY_W'(w) : wr_hit_way_s;
      wr_hit_s     = wr_hit_s | (valid_q[wr_set_s][w] && (tag_q[wr_set_s][w] == wr_tag_s));
      inv_way_s    = !valid_q[wr_set_s][w] ? WAY_W'(w) : inv_way_s;
      inv_s        = inv_s | !valid_q[wr_set_s][w];
      lru_way_s    = (age_q[wr_set_s][w] == AGE_MAX) ? WAY_W'(w) : lru_way_s;
    end
    if (wr_hit_s) begin
      wr_way_s = wr_hit_way_s;
    end else if (inv_s) begin
      wr_way_s = inv_way_s;
    end else begin
      wr_way_s = lru_way_s;
    end
  end

  // Table next state: hit touch, ENTRY write (wins over touch), flush clear (wins over both)
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    age_d   = age_q;
    if (entry_we_s) begin
      valid_d[wr_set_s][wr_way_s] = 1'b1;
      tag_d[wr_set_s][wr_way_s]   = wr_tag_s;
      data_d[wr_set_s][wr_way_s]  = sasa_data[15:0];
      for (int w = 0; w < SASA_WAYS; w++) begin
        age_d[wr_set_s][w] = age_next(age_q[wr_set_s][w], age_q[wr_set_s][wr_way_s],
                                      WAY_W'(w) == wr_way_s);
      end
    end else if (hit_s) begin
      for (int w = 0; w < SASA_WAYS; w++) begin
        age_d[lk_set_s][w] = age_next(age_q[lk_set_s][w], age_q[lk_set_s][hit_way_s],
                                      WAY_W'(w) == hit_way_s);
      end
    end else begin
      age_d = age_q;
    end
    if (busy_s) begin
      valid_d[fl_cnt_q] = '0;
      for (int w = 0; w < SASA_WAYS; w++) begin
        age_d[fl_cnt_q][w] = AGE_W'(SASA_WAYS - 1 - w);
      end
    end else begin
      valid_d[fl_cnt_q] = valid_d[fl_cnt_q];
    end
  end

  // Flush sequencer; a CONTROL write always (re)starts at set 0
  always_comb begin
    state_d  = state_q;
    fl_cnt_d = fl_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_we_s) begin
          state_d  = ST_FLUSH;
          fl_cnt_d = '0;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (ctrl_we_s) begin
          fl_cnt_d = '0;
        end else if (fl_cnt_q == SET_W'(SETS - 1)) begin
          state_d  = ST_IDLE;
        end else begin
          fl_cnt_d = fl_cnt_q + SET_W'(1);
        end
      end
      default: begin
        state_d  = ST_IDLE;
        fl_cnt_d = '0;
      end
    endcase
  end

  // Config, hit counter (clear beats increment) and read-back mux
  always_comb begin
    dis_d    = dis_q;
    hitcnt_d = hitcnt_q;
    rdata_d  = rdata_q;
    if (wr_s && sel_cfg_s) begin
      dis_d = sasa_data[0];
    end else begin
      dis_d = dis_q;
    end
    if (wr_s && sel_hit_s) begin
      hitcnt_d = 32'h0;
    end else if (valid_s && pc_valid && (hitcnt_q != 32'hFFFF_FFFF)) begin
      hitcnt_d = hitcnt_q + 32'd1;
    end else begin
      hitcnt_d = hitcnt_q;
    end
    if (rd_s) begin
      if (sel_cfg_s) begin
        rdata_d = {31'h0, dis_q};
      end else if (sel_ctrl_s) begin
        rdata_d = {31'h0, busy_s};
      end else if (sel_hit_s) begin
        rdata_d = hitcnt_q;
      end else begin
        rdata_d = 32'h0;
      end
    end else begin
      rdata_d = rdata_q;
    end
  end

  // State registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < SASA_WAYS; w++) begin
          tag_q[s][w]  <= '0;
          data_q[s][w] <= 16'h0;
          age_q[s][w]  <= AGE_W'(SASA_WAYS - 1 - w);
        end
      end
      state_q  <= ST_IDLE;
      fl_cnt_q <= '0;
      dis_q    <= 1'b0;
      hitcnt_q <= 32'h0;
      rdata_q  <= 32'h0;
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      data_q   <= data_d;
      age_q    <= age_d;
      state_q  <= state_d;
      fl_cnt_q <= fl_cnt_d;
      dis_q    <= dis_d;
      hitcnt_q <= hitcnt_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule
